// File: rtl/tcp_tx_header.sv
// tcp_tx_header: queues SYN/ACK/FIN requests and serialises a 20-byte TCP header onto a byte stream.
// Optional TCP_TX_CHECKSUM_EN adds src_ip/dst_ip ports and a CSUM state computing the TCP checksum.
module tcp_tx_header #(
  parameter logic [15:0] WINDOW_SIZE = 16'h0400
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] src_port,
  input  logic [15:0] dst_port,
`ifdef TCP_TX_CHECKSUM_EN
  input  logic [31:0] src_ip,
  input  logic [31:0] dst_ip,
`endif
  input  logic [31:0] isn,
  input  logic        isn_load,
  input  logic [31:0] ack_num_in,
  input  logic        ack_num_load,
  input  logic        syn_send,
  input  logic        ack_send,
  input  logic        fin_send,
  output logic [7:0]  m_tdata,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic        m_tlast,
  output logic        busy,
  output logic [31:0] seq_num_out
);
  typedef enum logic [1:0] {IDLE, HDR, CSUM} state_t;
  state_t state, state_n;
  logic [4:0] cnt;
  logic pend_syn, pend_ack, pend_fin, cap_syn, cap_ack, cap_fin;
  logic [31:0] seq_num, ack_reg, seq_snap, ack_snap;
  logic [15:0] src_snap, dst_snap, chk;
  logic capture, beat, done;
  logic [159:0] hdr;
  logic [19:0][7:0] hb;
  assign capture = (state == IDLE) && (pend_syn || pend_ack || pend_fin);
  assign m_tvalid = (state == HDR);
  assign beat = m_tvalid && m_tready;
  assign done = beat && (cnt == 5'd19);
  assign busy = (state != IDLE);
  assign seq_num_out = seq_num;
  assign hdr = {src_snap, dst_snap, seq_snap, cap_ack ? ack_snap : 32'h0, 8'h50,
                {3'b000, cap_ack, 2'b00, cap_syn, cap_fin}, WINDOW_SIZE, chk, 16'h0000};
  assign hb = hdr;
  assign m_tdata = m_tvalid ? hb[5'd19 - cnt] : 8'h00;
  assign m_tlast = m_tvalid && (cnt == 5'd19);
`ifdef TCP_TX_CHECKSUM_EN
  logic [4:0] ccnt;
  logic [31:0] acc;
  logic [15:0] csum;
  logic [15:0][15:0] wd;
  assign wd = {src_ip, dst_ip, 16'h0006, 16'h0014, hdr[159:32], 32'h0};
  assign chk = csum;
  always_comb
    state_n = capture ? CSUM : (state == CSUM && ccnt == 5'd17) ? HDR : done ? IDLE : state;
  // 16 summing cycles, then two carry folds, the second also inverting
  always_ff @(posedge clk) begin
    if (rst) begin
      ccnt <= '0;
      acc <= '0;
      csum <= '0;
    end else if (capture) begin
      ccnt <= '0;
      acc <= '0;
    end else if (state == CSUM) begin
      ccnt <= ccnt + 5'd1;
      if (ccnt < 5'd16) acc <= acc + {16'h0, wd[4'd15 - ccnt[3:0]]};
      else if (ccnt == 5'd16) acc <= {16'h0, acc[15:0]} + {16'h0, acc[31:16]};
      else csum <= ~(acc[15:0] + acc[31:16]);
    end
  end
`else
  assign chk = 16'h0000;
  always_comb state_n = capture ? HDR : done ? IDLE : state;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      {pend_syn, pend_ack, pend_fin} <= '0;
      {cap_syn, cap_ack, cap_fin} <= '0;
      seq_num <= '0;
      ack_reg <= '0;
      seq_snap <= '0;
      ack_snap <= '0;
      src_snap <= '0;
      dst_snap <= '0;
    end else begin
      state <= state_n;
      pend_syn <= syn_send | (pend_syn & ~capture);
      pend_ack <= ack_send | (pend_ack & ~capture);
      pend_fin <= fin_send | (pend_fin & ~capture);
      if (ack_num_load) ack_reg <= ack_num_in;
      if (capture) begin
        {cap_syn, cap_ack, cap_fin} <= {pend_syn, pend_ack, pend_fin};
        seq_snap <= seq_num;
        ack_snap <= ack_reg;
        src_snap <= src_port;
        dst_snap <= dst_port;
        cnt <= '0;
      end else if (beat) cnt <= done ? 5'd0 : cnt + 5'd1;
      seq_num <= isn_load ? isn : done ? seq_snap + {31'h0, cap_syn} + {31'h0, cap_fin} : seq_num;
    end
  end
endmodule

// File: tb/tb_tcp_tx_header.sv
// tb_tcp_tx_header: directed checks of tcp_tx_header framing, flags, sequence tracking and reset.
module tb_tcp_tx_header;
  logic clk = 0, rst = 1;
  logic [15:0] src_port = 0, dst_port = 0;
  logic [31:0] isn = 0, ack_num_in = 0;
  logic isn_load = 0, ack_num_load = 0, syn_send = 0, ack_send = 0, fin_send = 0;
  logic [7:0] m_tdata;
  logic m_tvalid, m_tready = 1, m_tlast, busy;
  logic [31:0] seq_num_out;
  int n_cmp = 0, n_err = 0, w;
  logic [7:0] fb [20];

  tcp_tx_header dut (
    .clk(clk), .rst(rst), .src_port(src_port), .dst_port(dst_port),
    .isn(isn), .isn_load(isn_load), .ack_num_in(ack_num_in), .ack_num_load(ack_num_load),
    .syn_send(syn_send), .ack_send(ack_send), .fin_send(fin_send),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .busy(busy), .seq_num_out(seq_num_out)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic pulse(input logic s, input logic a, input logic f);
    syn_send = s;
    ack_send = a;
    fin_send = f;
    step();
    {syn_send, ack_send, fin_send} = 3'b000;
  endtask

  task automatic get_frame(input int stall_at, input int pulse_at, input int rst_at, output int waits);
    logic [7:0] d;
    waits = 0;
    while (!m_tvalid && waits < 40) begin
      step();
      waits++;
    end
    if (!m_tvalid) begin
      check("tvalid_timeout", 0, 1);
      return;
    end
    check("busy_hdr", busy, 1);
    for (int i = 0; i < 20; i++) begin
      if (i == rst_at) begin
        rst = 1;
        step();
        rst = 0;
        return;
      end
      check($sformatf("tvalid[%0d]", i), m_tvalid, 1);
      if (i == stall_at) begin
        m_tready = 0;
        d = m_tdata;
        for (int k = 0; k < 3; k++) begin
          step();
          check("hold_data", m_tdata, d);
          check("hold_last", m_tlast, 0);
        end
        m_tready = 1;
      end
      ack_send = (i == pulse_at);
      fb[i] = m_tdata;
      check($sformatf("tlast[%0d]", i), m_tlast, i == 19);
      step();
    end
    ack_send = 0;
    check("gap_tvalid", m_tvalid, 0);
  endtask

  task automatic check_frame(input string tag, input logic [159:0] e);
    for (int i = 0; i < 20; i++)
      check($sformatf("%s_byte%0d", tag, i), fb[i], e[159-8*i -: 8]);
  endtask

  initial begin
    repeat (2) step();
    check("rst_tvalid", m_tvalid, 0);
    check("rst_tdata", m_tdata, 0);
    check("rst_tlast", m_tlast, 0);
    check("rst_busy", busy, 0);
    check("rst_seq", seq_num_out, 0);
    rst = 0;
    src_port = 16'h04D2;
    dst_port = 16'h0050;
    isn = 32'h1000_0000;
    isn_load = 1;
    step();
    isn_load = 0;
    check("isn_load", seq_num_out, 32'h1000_0000);

    pulse(1, 0, 0);
    get_frame(-1, -1, -1, w);
    check_frame("syn", 160'h04D2_0050_1000_0000_0000_0000_5002_0400_0000_0000);
    check("syn_seq", seq_num_out, 32'h1000_0001);

    ack_num_in = 32'h2000_0001;
    ack_num_load = 1;
    step();
    ack_num_load = 0;
    pulse(0, 1, 0);
    get_frame(-1, -1, -1, w);
    check_frame("ack", 160'h04D2_0050_1000_0001_2000_0001_5010_0400_0000_0000);
    check("ack_seq", seq_num_out, 32'h1000_0001);

    pulse(1, 1, 0);
    get_frame(-1, -1, -1, w);
    check_frame("synack", 160'h04D2_0050_1000_0001_2000_0001_5012_0400_0000_0000);
    check("synack_seq", seq_num_out, 32'h1000_0002);
    repeat (3) step();
    check("no_extra_frame", m_tvalid, 0);
    pulse(0, 1, 1);
    get_frame(-1, -1, -1, w);
    check_frame("finack", 160'h04D2_0050_1000_0002_2000_0001_5011_0400_0000_0000);
    check("finack_seq", seq_num_out, 32'h1000_0003);

    pulse(0, 1, 0);
    get_frame(5, -1, -1, w);
    check_frame("bp", 160'h04D2_0050_1000_0003_2000_0001_5010_0400_0000_0000);
    check("bp_seq", seq_num_out, 32'h1000_0003);

    isn = 32'hFFFF_FFFF;
    isn_load = 1;
    step();
    isn_load = 0;
    pulse(0, 0, 1);
    get_frame(-1, 10, -1, w);
    check_frame("wrapfin", 160'h04D2_0050_FFFF_FFFF_0000_0000_5001_0400_0000_0000);
    check("wrap_seq", seq_num_out, 32'h0000_0000);
    get_frame(-1, -1, -1, w);
    check("queued_gap", w, 1);
    check_frame("queued", 160'h04D2_0050_0000_0000_2000_0001_5010_0400_0000_0000);

    isn = 32'h1234_5678;
    isn_load = 1;
    step();
    isn_load = 0;
    pulse(0, 1, 0);
    get_frame(-1, 3, 8, w);
    check("midrst_tvalid", m_tvalid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_seq", seq_num_out, 0);
    check("midrst_tlast", m_tlast, 0);
    repeat (5) step();
    check("midrst_pend_tvalid", m_tvalid, 0);
    check("midrst_pend_busy", busy, 0);
    pulse(0, 1, 0);
    get_frame(-1, -1, -1, w);
    check_frame("postrst", 160'h04D2_0050_0000_0000_0000_0000_5010_0400_0000_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
